// File: rtl/vscale_hasti_arbiter.sv
// Two-master AHB-lite arbiter in front of one shared SRAM slave port.
// Latency: an uncontended transfer is forwarded in the cycle it is presented; a losing or stalled one waits in a pending buffer.
// Backpressure: grants only issue while s_hready=1; a master sees hready low while buffered, just granted, or stalled in its data phase.
module vscale_hasti_arbiter (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hready,
  input  logic        s_hresp
);

  localparam logic [1:0] HTRANS_IDLE = 2'd0;

  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_M0   = 2'd1,
    DP_M1   = 2'd2
  } dp_owner_t;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
  } addr_phase_t;

  addr_phase_t [1:0] live;
  addr_phase_t [1:0] pend;
  addr_phase_t [1:0] cand;
  addr_phase_t       sel;
  logic [1:0]        pend_vld;
  logic [1:0]        owns;
  logic [1:0]        hready_pre;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        cap;
  logic              last_grant;   // 0 = M0 was granted last, 1 = M1
  logic [31:0]       held_haddr;
  logic              held_hwrite;
  logic [2:0]        held_hsize;
  dp_owner_t         dp_owner;
  dp_owner_t         dp_owner_nxt;

  assign live[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_htrans};
  assign live[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_htrans};
  assign owns    = {dp_owner == DP_M1, dp_owner == DP_M0};

  // Request, round-robin grant and capture decisions for the current cycle.
  // hready_pre is the master's hready without the "granted now" term; using
  // it for req/capture avoids a grant -> hready -> req combinational loop.
  always_comb begin
    hready_pre = 2'b00;
    req        = 2'b00;
    cap        = 2'b00;
    gnt        = 2'b00;
    cand       = '0;
    for (int i = 0; i < 2; i++) begin
      hready_pre[i] = owns[i] ? s_hready : !pend_vld[i];
      req[i]        = !hreset && (pend_vld[i] || (live[i].htrans[1] && hready_pre[i]));
      cand[i]       = pend_vld[i] ? pend[i] : live[i];
    end
    if (s_hready && !hreset) begin
      if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
      else if (req[1])                       gnt[1] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      cap[i] = !hreset && live[i].htrans[1] && hready_pre[i] && !gnt[i];
    end
    sel = gnt[1] ? cand[1] : cand[0];
  end

  // Data-phase owner next state: only advances when the slave accepts.
  always_comb begin
    dp_owner_nxt = dp_owner;
    if (s_hready) begin
      if (gnt[0])      dp_owner_nxt = DP_M0;
      else if (gnt[1]) dp_owner_nxt = DP_M1;
      else             dp_owner_nxt = DP_NONE;
    end
  end

  // Data-phase owner register.
  always_ff @(posedge hclk) begin
    if (hreset) dp_owner <= DP_NONE;
    else        dp_owner <= dp_owner_nxt;
  end

  // Pending buffers, round-robin history and held slave address fields.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      pend_vld    <= 2'b00;
      pend        <= '0;
      last_grant  <= 1'b1;
      held_haddr  <= '0;
      held_hwrite <= 1'b0;
      held_hsize  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          pend_vld[i] <= 1'b0;
        end else if (cap[i]) begin
          pend_vld[i] <= 1'b1;
          pend[i]     <= live[i];
        end
      end
      if (|gnt) begin
        last_grant  <= gnt[1];
        held_haddr  <= sel.haddr;
        held_hwrite <= sel.hwrite;
        held_hsize  <= sel.hsize;
      end
    end
  end

  assign s_haddr  = hreset ? 32'd0 : ((|gnt) ? sel.haddr : held_haddr);
  assign s_hwrite = (|gnt) ? sel.hwrite : held_hwrite;
  assign s_hsize  = (|gnt) ? sel.hsize  : held_hsize;
  assign s_htrans = (|gnt) ? sel.htrans : HTRANS_IDLE;
  assign s_hwdata = owns[0] ? m0_hwdata : (owns[1] ? m1_hwdata : 32'd0);

  assign m0_hready = hreset || (owns[0] ? s_hready : !(pend_vld[0] || gnt[0]));
  assign m1_hready = hreset || (owns[1] ? s_hready : !(pend_vld[1] || gnt[1]));
  assign m0_hresp  = !hreset && owns[0] && s_hresp;
  assign m1_hresp  = !hreset && owns[1] && s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  // A capture may only land in an empty buffer, and never coincides with a grant.
  a_cap_no_overwrite: assert property (@(posedge hclk) disable iff (hreset)
    !(cap[0] && pend_vld[0]) && !(cap[1] && pend_vld[1]));
  a_cap_not_granted: assert property (@(posedge hclk) disable iff (hreset)
    (cap & gnt) == 2'b00);

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: directed scenarios then randomized traffic.
// A transaction-level reference model predicts slave-side transfers and per-cycle master outputs.
// Expected results are queued at stimulus time and consumed by an independent monitor on the falling edge.
module tb_vscale_hasti_arbiter;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
  } xfer_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    logic [31:0] held_addr;
    logic        held_write;
    logic [2:0]  held_size;
    bit          hr0, hr1, rsp0, rsp1;
    logic [31:0] wd;
    logic [31:0] rd;
  } cyc_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hready, s_hresp;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;

  always #5 hclk = ~hclk;

  vscale_hasti_arbiter dut (
    .hclk(hclk), .hreset(hreset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_htrans(s_htrans),
    .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  int    checks = 0;
  int    errors = 0;
  xfer_t exp_q[$];
  cyc_t  cyc_q[$];

  // Reference model state: per-master waiting transfer, data-phase owner (-1 none),
  // last winner, last forwarded address fields, and bench-master hold state.
  bit    mp_vld[2];
  xfer_t mp[2];
  int    m_owner = -1;
  int    m_last  = 1;
  xfer_t m_held  = '0;
  bit    holding[2];
  xfer_t live_x[2];

  localparam xfer_t IDLE_X = '0;

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [1:0] t);
    xfer_t x;
    x.haddr = a; x.hwrite = w; x.hsize = 3'd2; x.htrans = t;
    return x;
  endfunction

  function automatic xfer_t rnd_x();
    xfer_t x;
    x.haddr  = $urandom & 32'hFFFF_FFFC;
    x.hwrite = 1'($urandom_range(0, 1));
    x.hsize  = 3'($urandom_range(0, 2));
    x.htrans = ($urandom_range(0, 9) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, predict outcome, queue expectations, advance the model.
  task automatic step(input xfer_t n0, input xfer_t n1, input bit shr, input bit rst,
                      input logic [31:0] wd0, input logic [31:0] wd1);
    xfer_t lv[2];
    xfer_t cx[2];
    bit    pre[2], cv[2], taken[2], capd[2];
    int    win;
    cyc_t  c;
    lv[0] = holding[0] ? live_x[0] : n0;
    lv[1] = holding[1] ? live_x[1] : n1;
    {m0_haddr, m0_hwrite, m0_hsize, m0_htrans} = lv[0];
    {m1_haddr, m1_hwrite, m1_hsize, m1_htrans} = lv[1];
    m0_hwdata = wd0;
    m1_hwdata = wd1;
    s_hready  = shr;
    hreset    = rst;
    s_hrdata  = $urandom;
    s_hresp   = 1'($urandom_range(0, 1));
    c = '{default: 0};
    c.rd = s_hrdata;
    if (rst) begin
      c.rst = 1;
      cyc_q.push_back(c);
      mp_vld = '{0, 0}; holding = '{0, 0};
      m_owner = -1; m_last = 1; m_held = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pre[i] = (m_owner == i) ? shr : !mp_vld[i];
        cv[i]  = mp_vld[i] || (lv[i].htrans[1] && pre[i]);
        cx[i]  = mp_vld[i] ? mp[i] : lv[i];
      end
      win = -1;
      if (shr) begin
        if (cv[0] && cv[1]) win = 1 - m_last;
        else if (cv[0])     win = 0;
        else if (cv[1])     win = 1;
      end
      c.gnt        = (win >= 0);
      c.held_addr  = m_held.haddr;
      c.held_write = m_held.hwrite;
      c.held_size  = m_held.hsize;
      c.hr0  = (m_owner == 0) ? shr : !(mp_vld[0] || win == 0);
      c.hr1  = (m_owner == 1) ? shr : !(mp_vld[1] || win == 1);
      c.rsp0 = (m_owner == 0) && s_hresp;
      c.rsp1 = (m_owner == 1) && s_hresp;
      c.wd   = (m_owner == 0) ? wd0 : ((m_owner == 1) ? wd1 : 32'd0);
      if (win >= 0) exp_q.push_back(cx[win]);
      cyc_q.push_back(c);
      for (int i = 0; i < 2; i++) begin
        capd[i]  = lv[i].htrans[1] && pre[i] && (win != i);
        taken[i] = capd[i] || (win == i && !mp_vld[i]);
        if (win == i)     mp_vld[i] = 0;
        else if (capd[i]) begin mp_vld[i] = 1; mp[i] = lv[i]; end
        holding[i] = lv[i].htrans[1] && !taken[i];
        live_x[i]  = lv[i];
      end
      if (shr) m_owner = win;
      if (win >= 0) begin m_last = win; m_held = cx[win]; end
    end
    @(posedge hclk); #1;
  endtask

  task automatic st(input xfer_t n0, input xfer_t n1, input bit shr);
    step(n0, n1, shr, 1'b0, $urandom, $urandom);
  endtask

  // Monitor: compare DUT outputs against the queued expectations each falling edge.
  initial begin
    forever begin
      @(negedge hclk);
      if (cyc_q.size() > 0) begin
        cyc_t  c;
        xfer_t x;
        c = cyc_q.pop_front();
        if (c.rst) begin
          chk("rst_s_htrans", 32'(s_htrans), 32'd0);
          chk("rst_s_haddr", s_haddr, 32'd0);
          chk("rst_m0_hready", 32'(m0_hready), 32'd1);
          chk("rst_m1_hready", 32'(m1_hready), 32'd1);
          chk("rst_m0_hresp", 32'(m0_hresp), 32'd0);
          chk("rst_m1_hresp", 32'(m1_hresp), 32'd0);
        end else begin
          chk("grant_active", 32'(s_htrans[1]), 32'(c.gnt));
          if (c.gnt) begin
            x = exp_q.pop_front();
            chk("s_haddr", s_haddr, x.haddr);
            chk("s_hwrite", 32'(s_hwrite), 32'(x.hwrite));
            chk("s_hsize", 32'(s_hsize), 32'(x.hsize));
            chk("s_htrans", 32'(s_htrans), 32'(x.htrans));
          end else begin
            chk("idle_htrans", 32'(s_htrans), 32'd0);
            chk("held_haddr", s_haddr, c.held_addr);
            chk("held_hwrite", 32'(s_hwrite), 32'(c.held_write));
            chk("held_hsize", 32'(s_hsize), 32'(c.held_size));
          end
          chk("m0_hready", 32'(m0_hready), 32'(c.hr0));
          chk("m1_hready", 32'(m1_hready), 32'(c.hr1));
          chk("m0_hresp", 32'(m0_hresp), 32'(c.rsp0));
          chk("m1_hresp", 32'(m1_hresp), 32'(c.rsp1));
          chk("s_hwdata", s_hwdata, c.wd);
        end
        chk("m0_hrdata", m0_hrdata, c.rd);
        chk("m1_hrdata", m1_hrdata, c.rd);
      end
    end
  end

  initial begin
    {m0_haddr, m0_hwrite, m0_hsize, m0_htrans} = '0;
    {m1_haddr, m1_hwrite, m1_hsize, m1_htrans} = '0;
    m0_hwdata = '0; m1_hwdata = '0; s_hrdata = '0;
    s_hready = 1'b1; s_hresp = 1'b0; hreset = 1'b1;
    @(posedge hclk); #1;
    step(IDLE_X, IDLE_X, 1, 1, 0, 0);
    step(IDLE_X, IDLE_X, 1, 1, 0, 0);
    // Lone M0 read goes straight through, then its data phase.
    st(mk(32'h100, 0, 2), IDLE_X, 1);
    st(IDLE_X, IDLE_X, 1);
    // Simultaneous requests: M0 first, M1 buffered then issued.
    st(mk(32'h10, 1, 2), mk(32'h20, 0, 2), 1);
    for (int k = 0; k < 3; k++) st(IDLE_X, IDLE_X, 1);
    // Continuous contention alternates the grant.
    for (int k = 0; k < 6; k++)
      st(mk(32'h200 + 32'(4 * k), 0, 3), mk(32'h300 + 32'(4 * k), 1, 3), 1);
    for (int k = 0; k < 3; k++) st(IDLE_X, IDLE_X, 1);
    // Slave stall in M0 data phase while M1 presents 0x40.
    st(mk(32'h30, 0, 2), IDLE_X, 1);
    st(IDLE_X, mk(32'h40, 0, 2), 0);
    for (int k = 0; k < 2; k++) st(IDLE_X, IDLE_X, 0);
    for (int k = 0; k < 3; k++) st(IDLE_X, IDLE_X, 1);
    // M1 write data routed to the slave only during its data phase.
    st(IDLE_X, mk(32'h50, 1, 2), 1);
    step(IDLE_X, IDLE_X, 1, 0, 32'h1234_5678, 32'hDEAD_BEEF);
    step(IDLE_X, IDLE_X, 1, 0, 32'h1234_5678, 32'hDEAD_BEEF);
    // Reset while M1's transfer is buffered: it must never reappear.
    st(IDLE_X, mk(32'h70, 0, 2), 0);
    step(IDLE_X, IDLE_X, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) st(IDLE_X, IDLE_X, 1);
    // Randomized traffic with slave stalls and occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) step(IDLE_X, IDLE_X, 1, 1, 0, 0);
      else st(rnd_x(), rnd_x(), $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 6; k++) st(IDLE_X, IDLE_X, 1);
    @(negedge hclk); #1;
    chk("scoreboard_drained", 32'(exp_q.size() + cyc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_arbiter.md
VSCALE_HASTI_ARBITER -- requirements
Module: vscale_hasti_arbiter

Interface
REQ-001 The arbiter SHALL have one clock and a synchronous, active-high reset; the port list starts with hclk and hreset.
REQ-002 hclk  input  1  clock; all state updates on the rising edge.
REQ-003 hreset  input  1  synchronous active-high reset.
REQ-004 m0_haddr, m1_haddr  input  32  master address-phase address.
REQ-005 m0_hwrite, m1_hwrite  input  1  master write flag.
REQ-006 m0_hsize, m1_hsize  input  3  master transfer size (BYTE=0, HALFWORD=1, WORD=2).
REQ-007 m0_htrans, m1_htrans  input  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 m0_hwdata, m1_hwdata  input  32  master data-phase write data.
REQ-009 m0_hrdata, m1_hrdata  output  32  read data returned to the master.
REQ-010 m0_hready, m1_hready  output  1  per-master transfer-complete and address-accept signal.
REQ-011 m0_hresp, m1_hresp  output  1  per-master response (OKAY=0, ERROR=1).
REQ-012 s_haddr 32, s_hwrite 1, s_hsize 3, s_htrans 2, s_hwdata 32  output  signals driven to the shared SRAM slave.
REQ-013 s_hrdata 32, s_hready 1, s_hresp 1  input  signals returned from the slave.

Function
REQ-014 A master's transfer SHALL count as active when its htrans is NONSEQ or SEQ; IDLE and BUSY SHALL never be forwarded.
REQ-015 Each master SHALL have one pending buffer (valid, haddr, hwrite, hsize, htrans).
REQ-016 A master SHALL be captured into its pending buffer when all of these hold: its hready is 1, its transfer is active, and it is not granted this cycle.
REQ-017 req_i SHALL equal pending_i.valid OR (live active transfer AND mi_hready=1); when the pending buffer is valid it takes precedence over the live bus.
REQ-018 Grants SHALL be issued only in cycles where s_hready=1.
REQ-019 With a single request, that requester SHALL win. With both requesting, the master not recorded in last_grant SHALL win (round-robin). last_grant SHALL update on every grant.
REQ-020 The granted master's address-phase fields (from its pending buffer if valid, else live) SHALL drive s_haddr, s_hwrite, s_hsize and s_htrans.
REQ-021 With no grant, s_htrans SHALL be IDLE and the other s_* address-phase fields SHALL hold the last-granted values.
REQ-022 A granted pending buffer SHALL be cleared on the same edge.
REQ-023 The dp_owner register (NONE/M0/M1) SHALL update only when s_hready=1: to the granted master, or to NONE if there is no grant.
REQ-024 s_hwdata SHALL be the hwdata of dp_owner, or 0 when dp_owner is NONE.
REQ-025 mi_hready SHALL be s_hready if dp_owner=i; otherwise 0 if pending_i is valid or mi is the granted master this cycle; otherwise 1.
REQ-026 mi_hresp SHALL be s_hresp if dp_owner=i, else OKAY.
REQ-027 m0_hrdata and m1_hrdata SHALL both equal s_hrdata.
REQ-028 Latency: an uncontended transfer SHALL reach the slave in the same cycle it is presented (zero added cycles). A transfer that loses or is captured SHALL reach the slave no later than 2 slave-accepted slots later.
REQ-029 Simultaneous capture and grant for the same master SHALL be impossible; grant takes priority.
REQ-030 A capture SHALL never overwrite a valid pending buffer; this is guaranteed by REQ-025 and SHALL be covered by an assertion.
REQ-031 While s_hready=0, no state SHALL change except captures allowed by REQ-016.

Reset
REQ-032 On hreset=1 at a clock edge, the block SHALL clear both pending buffers, set dp_owner=NONE and set last_grant=M1, so M0 wins the first tie.
REQ-033 While hreset is asserted, outputs SHALL be: s_htrans=IDLE, m0_hready=m1_hready=1, m0_hresp=m1_hresp=OKAY, s_haddr=0.
REQ-034 Reset asserted mid-transfer SHALL drop any in-flight or pending transfer without replay.

Verification
REQ-035 After reset, M0 issues NONSEQ read 0x100 alone with s_hready=1 -> s_haddr=0x100 in the same cycle; next cycle m0_hready=1 and m0_hrdata=s_hrdata.
REQ-036 Both masters issue NONSEQ in the same cycle (M0 write 0x10, M1 read 0x20) -> M0 granted first and M1 captured; M1 issued next cycle with m1_hready=0 until its data phase completes.
REQ-037 Both masters request continuously for 6 cycles -> grants alternate M0, M1, M0, M1, ... with no master starved.
REQ-038 s_hready held 0 for 3 cycles during an M0 data phase while M1 presents 0x40 -> m0_hready=0 for 3 cycles and M1 captured; 0x40 reaches the slave on the first cycle with s_hready=1.
REQ-039 M1 write data phase of 0xDEADBEEF -> s_hwdata=0xDEADBEEF exactly during M1's data phase; s_hwdata=0 while dp_owner=NONE.
REQ-040 hreset pulsed while pending_1 is valid -> pending cleared, s_htrans=IDLE and both hready=1 the cycle after; no replay occurs.
